strip_occupancy_writeback: RTL and testbench
============================================

Name: strip_occupancy_writeback

Overview:
- Stage 6 of the multi-program placement pipeline, directly downstream of the min-strip search / strike-detect stages.
- Consumes the registered selection result: strip id, its current occupied width, strike flag and new occupied width.
- Commits accepted placements to a per-strip occupancy table and emits the placement x-coordinate.
- Exposes three combinational read ports so the upstream candidate stage reads current occupancy, with write-through bypass.

Parameters:
- NUM_STRIPS, 16, number of strips in the table; ids 0..NUM_STRIPS-1 valid, max 16.
- STRIP_WIDTH, 128, maximum legal occupied width per strip.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  selection result below is valid this cycle.
- min_occupied_strip_id  in  4  selected strip.
- min_occupied_strip_width  in  8  occupied width before placement (= placement x).
- strike_flag  in  1  program does not fit.
- new_occupied_strip_width  in  8  occupied width after placement.
- clear_req  in  1  start a table clear sweep.
- rd_id_1, rd_id_2, rd_id_3  in  4 each  read addresses from upstream.
- rd_width_1, rd_width_2, rd_width_3  out  8 each  occupancy of rd_id_n, combinational.
- place_valid  out  1  placement result valid.
- place_strike  out  1  result rejected, no table update.
- place_strip_id  out  4  strip used.
- place_x  out  8  x-coordinate of placed program.
- busy  out  1  clear sweep in progress.
- placed_count  out  CNT_W  accepted placements (saturating).
- strike_count  out  CNT_W  rejected results (saturating).

Behaviour:
- Reset, asynchronous:
  - all table entries 0; FSM to RUN.
  - place_valid, place_strike, busy = 0; place_strip_id, place_x = 0; counters 0.
- FSM states:
  - RUN: normal operation.
  - CLEAR: sweep pointer 0..NUM_STRIPS-1, one entry written to 0 per cycle.
- Transitions:
  - RUN -> CLEAR when clear_req=1.
  - CLEAR -> RUN after writing entry NUM_STRIPS-1, i.e. exactly NUM_STRIPS cycles in CLEAR.
  - clear_req during CLEAR: ignored; the sweep does not restart.
- busy = 1 exactly while the FSM is in CLEAR (registered).
- Input acceptance:
  - in_valid is accepted only in RUN with clear_req=0.
  - in_valid during CLEAR, or coincident with clear_req: dropped, no output, not counted.
- Accept condition (acc): in_valid accepted AND strike_flag=0 AND id < NUM_STRIPS AND new_occupied_strip_width <= STRIP_WIDTH AND new_occupied_strip_width >= min_occupied_strip_width.
- Reject: an accepted in_valid that fails acc.
- Latency: outputs are registered, one cycle after in_valid.
  - place_valid=1 for one cycle.
  - place_strip_id = id.
  - place_x = min_occupied_strip_width.
  - place_strike = ~acc.
- Without an accepted input: place_valid=0 and the other place_* outputs hold their previous values.
- Table write: on acc, table[id] <= new_occupied_strip_width at the same edge that registers the outputs. A reject never writes.
- Read ports:
  - rd_width_n = table[rd_id_n].
  - Bypass: if acc this cycle and rd_id_n == id, rd_width_n = new_occupied_strip_width.
  - rd_id_n >= NUM_STRIPS: returns STRIP_WIDTH, so the strip looks full.
  - During CLEAR, bypass is off and entries not yet cleared show their old value.
- Back-to-back: consecutive in_valid to the same id each commit in order; the second sees the first's write.
- Counters, on each accepted input: placed_count++ on acc, strike_count++ on reject. Both saturate at all-ones and are not cleared by clear_req.

Optional Feature:
- Macro: STRIP_STATS_EN.
  - Defined: placed_count and strike_count behave as above.
  - Undefined: no counter registers; both outputs tied to 0.

Test Plan:
- Reset, then rd_id_1=3 -> rd_width_1=0; all place_* outputs and busy = 0.
- in_valid, id=3, width=0, new=40, strike=0 -> next cycle place_valid=1, place_x=0, place_strike=0; rd_width(3)=40; placed_count=1.
- Same cycle as that write, rd_id_2=3 -> rd_width_2=40 by bypass. The next input (id=3, width=40, new=100) -> place_x=40; table[3]=100.
- in_valid, id=5, strike=1 (also new=200 with strike=0) -> place_strike=1; table[5] unchanged; strike_count increments once per input.
- clear_req pulse -> busy=1 for exactly 16 cycles. in_valid mid-sweep is dropped with no place_valid. After the sweep, all entries read 0.
- Async reset asserted mid-sweep -> outputs immediately 0; FSM in RUN; table zeroed. With STRIP_STATS_EN undefined, counters read 0 throughout.

Source files
------------

// File: rtl/strip_occupancy_writeback.sv
// Placement writeback stage: commits accepted placements to the per-strip occupancy table,
// serves three bypassed read ports, and runs a table clear sweep. Optional macro: STRIP_STATS_EN.
module strip_occupancy_writeback #(
    parameter int NUM_STRIPS  = 16,
    parameter int STRIP_WIDTH = 128,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [3:0]       min_occupied_strip_id,
    input  logic [7:0]       min_occupied_strip_width,
    input  logic             strike_flag,
    input  logic [7:0]       new_occupied_strip_width,
    input  logic             clear_req,
    input  logic [3:0]       rd_id_1,
    input  logic [3:0]       rd_id_2,
    input  logic [3:0]       rd_id_3,
    output logic [7:0]       rd_width_1,
    output logic [7:0]       rd_width_2,
    output logic [7:0]       rd_width_3,
    output logic             place_valid,
    output logic             place_strike,
    output logic [3:0]       place_strip_id,
    output logic [7:0]       place_x,
    output logic             busy,
    output logic [CNT_W-1:0] placed_count,
    output logic [CNT_W-1:0] strike_count
);

    typedef enum logic {RUN, CLEAR} state_t;

    localparam logic [4:0] NS        = NUM_STRIPS[4:0];
    localparam logic [8:0] SW        = STRIP_WIDTH[8:0];
    localparam logic [7:0] FULL      = STRIP_WIDTH[7:0];
    localparam logic [3:0] LAST_PTR  = 4'(NUM_STRIPS - 1);

    state_t     state_q, state_d;
    logic [3:0] ptr_q, ptr_d;
    logic       busy_q, busy_d;
    logic       place_valid_q, place_valid_d;
    logic       place_strike_q, place_strike_d;
    logic [3:0] place_strip_id_q, place_strip_id_d;
    logic [7:0] place_x_q, place_x_d;
    logic [7:0] table_q [NUM_STRIPS];
    logic [7:0] table_d [NUM_STRIPS];
    logic       take;
    logic       acc;

    always_comb begin
        take = in_valid && (state_q == RUN) && !clear_req;
        acc  = take && !strike_flag
               && ({1'b0, min_occupied_strip_id} < NS)
               && ({1'b0, new_occupied_strip_width} <= SW)
               && (new_occupied_strip_width >= min_occupied_strip_width);
    end

    always_comb begin
        state_d          = state_q;
        ptr_d            = ptr_q;
        busy_d           = busy_q;
        table_d          = table_q;
        place_valid_d    = take;
        place_strike_d   = place_strike_q;
        place_strip_id_d = place_strip_id_q;
        place_x_d        = place_x_q;
        if (take) begin
            place_strike_d   = ~acc;
            place_strip_id_d = min_occupied_strip_id;
            place_x_d        = min_occupied_strip_width;
        end
        if (acc) begin
            table_d[min_occupied_strip_id] = new_occupied_strip_width;
        end
        case (state_q)
            RUN: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            CLEAR: begin
                table_d[ptr_q] = '0;
                ptr_d          = ptr_q + 4'd1;
                if (ptr_q == LAST_PTR) begin
                    state_d = RUN;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = RUN;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= RUN;
            ptr_q            <= '0;
            busy_q           <= 1'b0;
            place_valid_q    <= 1'b0;
            place_strike_q   <= 1'b0;
            place_strip_id_q <= '0;
            place_x_q        <= '0;
            for (int i = 0; i < NUM_STRIPS; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            state_q          <= state_d;
            ptr_q            <= ptr_d;
            busy_q           <= busy_d;
            place_valid_q    <= place_valid_d;
            place_strike_q   <= place_strike_d;
            place_strip_id_q <= place_strip_id_d;
            place_x_q        <= place_x_d;
            table_q          <= table_d;
        end
    end

    // Out-of-range ids read as full; an accepting write to the same id is forwarded.
    function automatic logic [7:0] read_entry(input logic [3:0] rid, input logic [7:0] entry);
        if ({1'b0, rid} >= NS) begin
            return FULL;
        end else if (acc && (rid == min_occupied_strip_id)) begin
            return new_occupied_strip_width;
        end else begin
            return entry;
        end
    endfunction

    assign rd_width_1     = read_entry(rd_id_1, table_q[rd_id_1]);
    assign rd_width_2     = read_entry(rd_id_2, table_q[rd_id_2]);
    assign rd_width_3     = read_entry(rd_id_3, table_q[rd_id_3]);
    assign place_valid    = place_valid_q;
    assign place_strike   = place_strike_q;
    assign place_strip_id = place_strip_id_q;
    assign place_x        = place_x_q;
    assign busy           = busy_q;

`ifdef STRIP_STATS_EN
    logic [CNT_W-1:0] placed_count_q, placed_count_d;
    logic [CNT_W-1:0] strike_count_q, strike_count_d;

    always_comb begin
        placed_count_d = placed_count_q;
        strike_count_d = strike_count_q;
        if (acc && (placed_count_q != '1)) begin
            placed_count_d = placed_count_q + CNT_W'(1);
        end
        if (take && !acc && (strike_count_q != '1)) begin
            strike_count_d = strike_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            placed_count_q <= '0;
            strike_count_q <= '0;
        end else begin
            placed_count_q <= placed_count_d;
            strike_count_q <= strike_count_d;
        end
    end

    assign placed_count = placed_count_q;
    assign strike_count = strike_count_q;
`else
    assign placed_count = '0;
    assign strike_count = '0;
`endif

endmodule

// File: tb/tb_strip_occupancy_writeback.sv
// Directed self-checking bench for strip_occupancy_writeback.
module tb_strip_occupancy_writeback;

`ifdef STRIP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [3:0]  min_occupied_strip_id;
    logic [7:0]  min_occupied_strip_width;
    logic        strike_flag;
    logic [7:0]  new_occupied_strip_width;
    logic        clear_req;
    logic [3:0]  rd_id_1, rd_id_2, rd_id_3;
    logic [7:0]  rd_width_1, rd_width_2, rd_width_3;
    logic        place_valid, place_strike, busy;
    logic [3:0]  place_strip_id;
    logic [7:0]  place_x;
    logic [15:0] placed_count, strike_count;

    int vectors = 0;
    int miscompares = 0;
    int busy_cnt;
    logic pv_seen;

    strip_occupancy_writeback dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .min_occupied_strip_id(min_occupied_strip_id),
        .min_occupied_strip_width(min_occupied_strip_width),
        .strike_flag(strike_flag),
        .new_occupied_strip_width(new_occupied_strip_width),
        .clear_req(clear_req),
        .rd_id_1(rd_id_1), .rd_id_2(rd_id_2), .rd_id_3(rd_id_3),
        .rd_width_1(rd_width_1), .rd_width_2(rd_width_2), .rd_width_3(rd_width_3),
        .place_valid(place_valid), .place_strike(place_strike),
        .place_strip_id(place_strip_id), .place_x(place_x), .busy(busy),
        .placed_count(placed_count), .strike_count(strike_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] id, input logic [7:0] w,
                                 input logic s, input logic [7:0] nw, input logic clr);
        in_valid                 = v;
        min_occupied_strip_id    = id;
        min_occupied_strip_width = w;
        strike_flag              = s;
        new_occupied_strip_width = nw;
        clear_req                = clr;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkPlace(input string tag, input logic v, input logic s,
                              input logic [3:0] id, input logic [7:0] x);
        checkOutput({tag, "_valid"}, 32'(place_valid), 32'(v));
        checkOutput({tag, "_strike"}, 32'(place_strike), 32'(s));
        checkOutput({tag, "_id"}, 32'(place_strip_id), 32'(id));
        checkOutput({tag, "_x"}, 32'(place_x), 32'(x));
    endtask

    initial begin
        rst = 1'b1;
        rd_id_1 = 4'd3; rd_id_2 = 4'd0; rd_id_3 = 4'd0;
        applyStimulus(1'b0, 4'd0, 8'd0, 1'b0, 8'd0, 1'b0);
        #22;
        rst = 1'b0;
        tick();

        // Reset state
        checkOutput("rst_rd1", 32'(rd_width_1), 32'd0);
        checkPlace("rst", 1'b0, 1'b0, 4'd0, 8'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_placed", 32'(placed_count), 32'd0);
        checkOutput("rst_strike", 32'(strike_count), 32'd0);

        // First write with same-cycle bypass on two ports
        rd_id_2 = 4'd3;
        applyStimulus(1'b1, 4'd3, 8'd0, 1'b0, 8'd40, 1'b0);
        checkOutput("byp_rd1", 32'(rd_width_1), 32'd40);
        checkOutput("byp_rd2", 32'(rd_width_2), 32'd40);
        tick();
        checkPlace("p1", 1'b1, 1'b0, 4'd3, 8'd0);
        checkOutput("p1_placed", 32'(placed_count), STATS ? 32'd1 : 32'd0);

        // Back-to-back to the same strip sees the first write
        applyStimulus(1'b1, 4'd3, 8'd40, 1'b0, 8'd100, 1'b0);
        checkOutput("b2b_byp", 32'(rd_width_2), 32'd100);
        tick();
        checkPlace("p2", 1'b1, 1'b0, 4'd3, 8'd40);
        applyStimulus(1'b0, 4'd0, 8'd0, 1'b0, 8'd0, 1'b0);
        checkOutput("t3_rd", 32'(rd_width_1), 32'd100);
        tick();
        checkPlace("idle", 1'b0, 1'b0, 4'd3, 8'd40);

        // Rejects: strike flag, then width beyond strip
        rd_id_1 = 4'd5;
        applyStimulus(1'b1, 4'd5, 8'd0, 1'b1, 8'd10, 1'b0);
        checkOutput("strk_nobyp", 32'(rd_width_1), 32'd0);
        tick();
        checkPlace("strk", 1'b1, 1'b1, 4'd5, 8'd0);
        applyStimulus(1'b1, 4'd5, 8'd0, 1'b0, 8'd200, 1'b0);
        checkOutput("wide_nobyp", 32'(rd_width_1), 32'd0);
        tick();
        checkPlace("wide", 1'b1, 1'b1, 4'd5, 8'd0);
        checkOutput("wide_rd", 32'(rd_width_1), 32'd0);
        checkOutput("strk_cnt2", 32'(strike_count), STATS ? 32'd2 : 32'd0);

        // Boundary: exactly full width accepted, shrinking width rejected
        rd_id_3 = 4'd7;
        applyStimulus(1'b1, 4'd7, 8'd0, 1'b0, 8'd128, 1'b0);
        tick();
        checkPlace("full", 1'b1, 1'b0, 4'd7, 8'd0);
        checkOutput("full_rd3", 32'(rd_width_3), 32'd128);
        rd_id_3 = 4'd8;
        applyStimulus(1'b1, 4'd8, 8'd50, 1'b0, 8'd40, 1'b0);
        tick();
        checkPlace("shrink", 1'b1, 1'b1, 4'd8, 8'd50);
        checkOutput("shrink_rd3", 32'(rd_width_3), 32'd0);
        checkOutput("placed3", 32'(placed_count), STATS ? 32'd3 : 32'd0);
        checkOutput("strike3", 32'(strike_count), STATS ? 32'd3 : 32'd0);

        // Clear sweep; in_valid coincident with clear_req is dropped
        rd_id_1 = 4'd3;
        applyStimulus(1'b1, 4'd3, 8'd0, 1'b0, 8'd50, 1'b1);
        tick();
        checkOutput("clr_busy", 32'(busy), 32'd1);
        checkOutput("clr_drop", 32'(place_valid), 32'd0);
        busy_cnt = 0;
        pv_seen = 1'b0;
        for (int i = 0; i < 40 && busy; i++) begin
            busy_cnt++;
            pv_seen = pv_seen | place_valid;
            if (i == 0) begin
                applyStimulus(1'b1, 4'd3, 8'd0, 1'b0, 8'd50, 1'b0);
                checkOutput("clr_old_nobyp", 32'(rd_width_1), 32'd100);
            end else if (i == 1) begin
                applyStimulus(1'b0, 4'd0, 8'd0, 1'b0, 8'd0, 1'b1);
            end else begin
                applyStimulus(1'b0, 4'd0, 8'd0, 1'b0, 8'd0, 1'b0);
            end
            tick();
        end
        checkOutput("clr_cycles", 32'(busy_cnt), 32'd16);
        checkOutput("clr_no_pv", 32'(pv_seen), 32'd0);
        for (int j = 0; j < 16; j++) begin
            rd_id_2 = 4'(j);
            #1;
            checkOutput("clr_entry", 32'(rd_width_2), 32'd0);
        end
        checkOutput("clr_keep_cnt", 32'(placed_count), STATS ? 32'd3 : 32'd0);

        // Async reset mid-sweep
        rd_id_1 = 4'd2;
        applyStimulus(1'b1, 4'd2, 8'd20, 1'b0, 8'd30, 1'b0);
        tick();
        checkPlace("pre_rst", 1'b1, 1'b0, 4'd2, 8'd20);
        applyStimulus(1'b0, 4'd0, 8'd0, 1'b0, 8'd0, 1'b1);
        tick();
        applyStimulus(1'b0, 4'd0, 8'd0, 1'b0, 8'd0, 1'b0);
        tick();
        checkOutput("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        checkPlace("arst", 1'b0, 1'b0, 4'd0, 8'd0);
        checkOutput("arst_busy", 32'(busy), 32'd0);
        checkOutput("arst_tbl", 32'(rd_width_1), 32'd0);
        checkOutput("arst_cnt", 32'(placed_count), 32'd0);
        #1;
        rst = 1'b0;
        applyStimulus(1'b1, 4'd4, 8'd0, 1'b0, 8'd10, 1'b0);
        tick();
        checkPlace("post_rst", 1'b1, 1'b0, 4'd4, 8'd0);
        checkOutput("post_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
